// File: rtl/foc_filter_pkg.sv
// foc_filter_pkg: shared sample type, accumulator width and rounding shift for the FOC filters
package foc_filter_pkg;
  localparam int SAMPLE_W = 16;
  typedef logic signed [SAMPLE_W-1:0] sample_t;
  function automatic int acc_w(input int data_w, input int log2_depth);
    return data_w + log2_depth;
  endfunction
  function automatic logic signed [63:0] round_shift(input logic signed [63:0] v, input int unsigned k);
    logic signed [63:0] half;
    half = (k > 0) ? (64'sd1 <<< (k - 1)) : 64'sd0;
    return (v + half) >>> k;
  endfunction
endpackage

// File: rtl/ma_channel.sv
// ma_channel: one channel history ring, write pointer, running sum and fill counter; ports: i_clk/i_rst/i_clr, i_we accept, i_k window exponent, i_data sample, o_sum_next/o_primed_next for the accepted sample
module ma_channel
  import foc_filter_pkg::*;
#(
  parameter int DATA_W = SAMPLE_W,
  parameter int LOG2_DEPTH_MAX = 4,
  localparam int KW = $clog2(LOG2_DEPTH_MAX + 1),
  localparam int ACC_W = acc_w(DATA_W, LOG2_DEPTH_MAX)
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_clr,
  input  logic                     i_we,
  input  logic [KW-1:0]            i_k,
  input  logic signed [DATA_W-1:0] i_data,
  output logic signed [ACC_W-1:0]  o_sum_next,
  output logic                     o_primed_next
);
  localparam int DEPTH = 2 ** LOG2_DEPTH_MAX;
  localparam int FW = LOG2_DEPTH_MAX + 1;
  logic signed [DATA_W-1:0] r_buf [DEPTH];
  logic [LOG2_DEPTH_MAX-1:0] r_wr_ptr;
  logic signed [ACC_W-1:0] r_sum;
  logic [FW-1:0] r_fill;
  logic [FW-1:0] w_span;
  logic [FW-1:0] w_fill_next;
  logic [LOG2_DEPTH_MAX-1:0] w_rd;
  logic signed [DATA_W-1:0] w_oldest;
  // a full-depth window wraps the offset to 0, so the oldest entry is the one being overwritten
  assign w_span = FW'(1) << i_k;
  assign w_rd = r_wr_ptr - w_span[LOG2_DEPTH_MAX-1:0];
  assign w_oldest = r_buf[w_rd];
  assign o_sum_next = r_sum + {{LOG2_DEPTH_MAX{i_data[DATA_W-1]}}, i_data}
                            - {{LOG2_DEPTH_MAX{w_oldest[DATA_W-1]}}, w_oldest};
  assign w_fill_next = (r_fill < w_span) ? r_fill + FW'(1) : r_fill;
  assign o_primed_next = w_fill_next >= w_span;
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst || i_clr) begin
      r_buf <= '{default: '0};
      r_wr_ptr <= '0;
      r_sum <= '0;
      r_fill <= '0;
    end else if (i_we) begin
      r_buf[r_wr_ptr] <= i_data;
      r_wr_ptr <= r_wr_ptr + 1'b1;
      r_sum <= o_sum_next;
      r_fill <= w_fill_next;
    end
  end
endmodule

// File: rtl/moving_average_filter.sv
// moving_average_filter: multi-channel power-of-two moving average; ports: i_clk/i_rst, i_clr + i_win_log2 window load, i_valid/i_ch/i_data tagged samples, o_valid/o_ch/o_data/o_primed registered rounded average
module moving_average_filter
  import foc_filter_pkg::*;
#(
  parameter int DATA_W = SAMPLE_W,
  parameter int CH_NUM = 3,
  parameter int LOG2_DEPTH_MAX = 4,
  localparam int KW = $clog2(LOG2_DEPTH_MAX + 1),
  localparam int CH_W = $clog2(CH_NUM)
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_clr,
  input  logic [KW-1:0]            i_win_log2,
  input  logic                     i_valid,
  input  logic [CH_W-1:0]          i_ch,
  input  logic signed [DATA_W-1:0] i_data,
  output logic                     o_valid,
  output logic [CH_W-1:0]          o_ch,
  output logic signed [DATA_W-1:0] o_data,
  output logic                     o_primed
);
  localparam int ACC_W = acc_w(DATA_W, LOG2_DEPTH_MAX);
  logic [KW-1:0] r_k;
  logic signed [ACC_W-1:0] w_sum_next [CH_NUM];
  logic [CH_NUM-1:0] w_primed_next;
  logic w_hit;
  logic [CH_W-1:0] w_sel;
  logic signed [ACC_W-1:0] w_sum;
  logic signed [DATA_W-1:0] w_avg;
  // unused tag codes are dropped here so no channel sees them
  assign w_hit = i_valid && !i_clr && (32'(i_ch) < CH_NUM);
  assign w_sel = w_hit ? i_ch : '0;
  assign w_sum = w_sum_next[w_sel];
  assign w_avg = DATA_W'(round_shift({{(64 - ACC_W){w_sum[ACC_W-1]}}, w_sum}, 32'(r_k)));
  for (genvar c = 0; c < CH_NUM; c++) begin : g_ch
    ma_channel #(
      .DATA_W(DATA_W),
      .LOG2_DEPTH_MAX(LOG2_DEPTH_MAX)
    ) u_ch (
      .i_clk(i_clk),
      .i_rst(i_rst),
      .i_clr(i_clr),
      .i_we(w_hit && (w_sel == CH_W'(c))),
      .i_k(r_k),
      .i_data(i_data),
      .o_sum_next(w_sum_next[c]),
      .o_primed_next(w_primed_next[c])
    );
  end
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)
      r_k <= KW'(LOG2_DEPTH_MAX);
    else if (i_clr)
      r_k <= (i_win_log2 > KW'(LOG2_DEPTH_MAX)) ? KW'(LOG2_DEPTH_MAX) : i_win_log2;
  end
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst || i_clr) begin
      o_valid <= 1'b0;
      o_ch <= '0;
      o_data <= '0;
      o_primed <= 1'b0;
    end else begin
      o_valid <= w_hit;
      if (w_hit) begin
        o_ch <= i_ch;
        o_data <= w_avg;
        o_primed <= w_primed_next[w_sel];
      end
    end
  end
endmodule

// File: tb/tb_moving_average_filter.sv
// tb_moving_average_filter: randomized and directed check of moving_average_filter against a sample-history model
module tb_moving_average_filter;
  import foc_filter_pkg::*;
  logic i_clk = 1'b0;
  logic i_rst, i_clr, i_valid;
  logic [2:0] i_win_log2;
  logic [1:0] i_ch, o_ch;
  sample_t i_data, o_data;
  logic o_valid, o_primed;
  int n_chk = 0;
  int n_fail = 0;
  int hist[3][$];
  int k_m;
  int t1[10] = '{13, 25, 38, 50, 63, 75, 88, 100, 100, 100};

  moving_average_filter dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_clr(i_clr), .i_win_log2(i_win_log2),
    .i_valid(i_valid), .i_ch(i_ch), .i_data(i_data),
    .o_valid(o_valid), .o_ch(o_ch), .o_data(o_data), .o_primed(o_primed)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #1ms;
    $display("FAIL timeout");
    $fatal(1);
  end

  task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    k_m = 4;
    for (int c = 0; c < 3; c++) hist[c].delete();
  endfunction

  function automatic int model_avg(input int c);
    int n, s, sz;
    n = 1 << k_m;
    s = 0;
    sz = hist[c].size();
    for (int i = 0; i < n && i < sz; i++) s += hist[c][sz-1-i];
    return (s + ((k_m > 0) ? (1 << (k_m - 1)) : 0)) >>> k_m;
  endfunction

  task automatic step(input logic v, input int ch, input int d, input logic clr, input int wl);
    int e_d;
    @(negedge i_clk);
    i_valid = v;
    i_ch = 2'(ch);
    i_data = 16'(d);
    i_clr = clr;
    i_win_log2 = 3'(wl);
    @(posedge i_clk);
    #1;
    if (clr) begin
      model_reset();
      k_m = (wl > 4) ? 4 : wl;
      check("clr_valid", o_valid, 0);
      check("clr_data", o_data, 0);
      check("clr_primed", o_primed, 0);
    end else if (v && ch < 3) begin
      hist[ch].push_back(d);
      if (hist[ch].size() > 16) void'(hist[ch].pop_front());
      e_d = model_avg(ch);
      check("valid", o_valid, 1);
      check("ch", o_ch, ch);
      check("data", o_data, e_d);
      check("primed", o_primed, (hist[ch].size() >= (1 << k_m)) ? 1 : 0);
    end else
      check("idle_valid", o_valid, 0);
  endtask

  initial begin
    i_rst = 1'b1; i_clr = 1'b0; i_valid = 1'b0; i_ch = '0; i_data = '0; i_win_log2 = '0;
    model_reset();
    repeat (2) @(posedge i_clk);
    #1;
    check("rst_valid", o_valid, 0);
    check("rst_ch", o_ch, 0);
    check("rst_data", o_data, 0);
    check("rst_primed", o_primed, 0);
    @(negedge i_clk);
    i_rst = 1'b0;
    // k=3 ramp on channel 0
    step(0, 0, 0, 1, 3);
    for (int i = 0; i < 10; i++) begin
      step(1, 0, 100, 0, $urandom_range(0, 7));
      check("t1_tab", o_data, t1[i]);
      check("t1_primed", o_primed, (i >= 7) ? 1 : 0);
    end
    // interleaved channels, k=2
    step(0, 0, 0, 1, 2);
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 1000, 0, 0);
      step(1, 1, -1000, 0, 0);
    end
    step(1, 0, 1000, 0, 0);
    check("t2_ch0", o_data, 1000);
    step(1, 1, -1000, 0, 0);
    check("t2_ch1", o_data, -1000);
    step(1, 2, 40, 0, 0);
    check("t2_ch2", o_data, 10);
    // extremes, k=4
    step(0, 0, 0, 1, 4);
    for (int i = 0; i < 16; i++) step(1, 1, 32767, 0, 0);
    check("t3_hi", o_data, 32767);
    for (int i = 0; i < 16; i++) step(1, 1, -32768, 0, 0);
    check("t3_lo", o_data, -32768);
    // k=0 passes samples straight through
    step(0, 0, 0, 1, 0);
    for (int i = 0; i < 8; i++) begin
      int d;
      d = int'($urandom_range(0, 65535)) - 32768;
      step(1, $urandom_range(0, 2), d, 0, 5);
      check("t4_pass", o_data, d);
      check("t4_primed", o_primed, 1);
    end
    // clear together with a sample drops the sample
    step(0, 0, 0, 1, 3);
    step(1, 0, 500, 0, 0);
    step(1, 0, 999, 1, 1);
    check("t5_drop", o_valid, 0);
    step(1, 0, 40, 0, 0);
    check("t5_half", o_data, 20);
    // async reset mid-stream, then clamp and ignored tag
    step(1, 0, 300, 0, 0);
    @(negedge i_clk);
    #2 i_rst = 1'b1;
    #1;
    check("t6_rst_valid", o_valid, 0);
    check("t6_rst_data", o_data, 0);
    model_reset();
    @(negedge i_clk);
    i_rst = 1'b0;
    step(0, 0, 0, 1, 7);
    step(1, 3, 1234, 0, 0);
    check("t6_tag3", o_valid, 0);
    step(1, 0, 160, 0, 0);
    check("t6_clamp", o_data, 10);
    // random traffic with occasional clears
    for (int i = 0; i < 400; i++) begin
      int d;
      d = int'($urandom_range(0, 65535)) - 32768;
      if ($urandom_range(0, 29) == 0)
        step($urandom_range(0, 1), $urandom_range(0, 3), d, 1, $urandom_range(0, 7));
      else
        step($urandom_range(0, 3) != 0, $urandom_range(0, 3), d, 0, $urandom_range(0, 7));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
